idma_desc64_submit_arb: RTL and testbench
=========================================

# idma_desc64_submit_arb

Round-robin arbiter that shares the single descriptor-address submission port of the 64-bit descriptor frontend between `NumReq` requesters (cores or clusters). Each requester pushes descriptor addresses over valid/ready. The block registers the granted address toward the frontend's input-address handshake and records the requester ID in an in-order ID FIFO. Frontend completion pulses are routed back to the originating requester. It sits directly in front of the frontend's register wrapper, on the descriptor-address write path.

## Interface
- `NumReq`, default 4: number of requesters, ≥2.
- `AddrWidth`, default 64: descriptor address width.
- `IdDepth`, default 8: max outstanding (submitted, not completed) descriptors, ≥2, power of two.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `req_valid_i` in NumReq: per-requester address valid.
- `req_addr_i` in NumReq×AddrWidth: per-requester descriptor address.
- `req_ready_o` out NumReq: per-requester accept; at most one bit high.
- `desc_addr_valid_o` out 1: address valid toward frontend.
- `desc_addr_o` out AddrWidth: granted descriptor address.
- `desc_addr_ready_i` in 1: frontend accepts address.
- `desc_done_i` in 1: one-cycle pulse per completed descriptor, in submission order.
- `req_done_o` out NumReq: one-cycle completion pulse to the owning requester.
- `outstanding_o` out $clog2(IdDepth+1): current ID FIFO occupancy.
- `busy_o` out 1: `desc_addr_valid_o | (outstanding_o != 0)`.
- `err_o` out 1: sticky; set when `desc_done_i` arrives with an empty ID FIFO.

## Operation
- Output stage is one register: `{valid_q, addr_q, id_q}`. Define `out_free = ~valid_q | desc_addr_ready_i`.
- Define `id_space = (count_q < IdDepth) | desc_done_i`.
- Grant when `out_free & id_space & |req_valid_i`. The winner is the first valid index strictly after `last_q`, wrapping modulo NumReq.
- `req_ready_o[w]` is asserted only for the winner, combinationally. Handshake = `req_valid_i[w] & req_ready_o[w]`.
- On handshake:
  - load `addr_q <= req_addr_i[w]` and `valid_q <= 1`;
  - write `w` to the ID FIFO;
  - set `last_q <= w`.
- If the output is accepted and there is no new grant, `valid_q <= 0`.
- ID FIFO is a circular buffer with `wr_ptr`/`rd_ptr` of $clog2(IdDepth) bits that wrap naturally, plus `count_q`.
  - Push on handshake; pop on `desc_done_i` when `count_q != 0`.
  - Simultaneous push and pop: count unchanged, both pointers advance. This is legal at full.
- Pop: `req_done_o[fifo[rd_ptr]]` pulses next cycle. All other `req_done_o` bits stay 0.
- `desc_done_i` with `count_q == 0`: no pop, no `req_done_o`, and `err_o <= 1` until reset.
- `desc_addr_o` and `desc_addr_valid_o` are held stable while `valid_q & ~desc_addr_ready_i`.
- Reset values:
  - `valid_q=0`, `addr_q=0`, `last_q=NumReq-1` (requester 0 wins first);
  - pointers and `count_q` = 0;
  - `req_done_o=0`, `err_o=0`.
- Reset mid-operation drops the held address and all outstanding IDs. Completions arriving after reset for pre-reset descriptors set `err_o`.

## Timing
- Handshake in cycle T puts `desc_addr_valid_o=1` with that address in T+1.
- Throughput is one address per cycle while `desc_addr_ready_i=1` and ID space remains.
- `desc_done_i` in T produces `req_done_o` in T+1.
- `outstanding_o` reflects `count_q`; it updates the cycle after the push or pop.
- There is no combinational path from `desc_addr_ready_i` to `desc_addr_o`. `req_ready_o` does depend combinationally on `desc_addr_ready_i`, `desc_done_i`, and `req_valid_i`.
- Requesters must hold `req_valid_i`/`req_addr_i` until accepted.

## Test plan
- Single request: after reset, requester 2 offers 0x1000 in cycle 0.
  - `req_ready_o=4'b0100` in cycle 0.
  - Cycle 1: `desc_addr_valid_o=1`, `desc_addr_o=0x1000`, `outstanding_o=1`.
  - `desc_done_i` in cycle 5 → `req_done_o=4'b0100` in cycle 6, `outstanding_o=0`.
- Round robin: all four requesters valid continuously and ready held high → grant order 0,1,2,3,0,1,2,3. Each requester gets exactly 2 of 8 grants.
- Backpressure: ready low for 5 cycles with address 0xA0 held → `desc_addr_o` stable at 0xA0. No further `req_ready_o` until ready rises. The next grant occurs in the same cycle as that acceptance.
- Full FIFO: 8 submissions with no done → `outstanding_o=8` and `req_ready_o=0`.
  - `desc_done_i` with a pending request → grant in the same cycle; `outstanding_o` stays 8.
  - Completions come back in order, to requester IDs matching submission order.
- Spurious done: `desc_done_i` at `outstanding_o=0` → `err_o=1` sticky, `req_done_o=0`. `rst_i` for one cycle clears `err_o`.
- Reset mid-flight: 3 outstanding plus a held address, then `rst_i` → next cycle `desc_addr_valid_o=0`, `outstanding_o=0`, `busy_o=0`. The first grant afterwards goes to requester 0 if it is valid.

Source files
------------

// File: rtl/idma_desc64_submit_arb.sv
// Round-robin arbiter sharing the descriptor-address submission port of the
// 64-bit descriptor frontend; an in-order ID FIFO routes completions back.
module idma_desc64_submit_arb #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdDepth   = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumReq-1:0]                   req_valid_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
  output logic [NumReq-1:0]                   req_ready_o,
  output logic                                desc_addr_valid_o,
  output logic [AddrWidth-1:0]                desc_addr_o,
  input  logic                                desc_addr_ready_i,
  input  logic                                desc_done_i,
  output logic [NumReq-1:0]                   req_done_o,
  output logic [$clog2(IdDepth+1)-1:0]        outstanding_o,
  output logic                                busy_o,
  output logic                                err_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned PtrW = $clog2(IdDepth);
  localparam int unsigned CntW = $clog2(IdDepth + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(IdDepth);

  logic                 valid_q;
  logic [AddrWidth-1:0] addr_q;
  logic [IdxW-1:0]      last_q;
  logic [IdxW-1:0]      fifo_q [IdDepth];
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic [NumReq-1:0]    done_q;
  logic                 err_q;

  logic            out_free;
  logic            id_space;
  logic            found;
  logic [IdxW-1:0] winner;
  logic            grant;
  logic            pop;

  // Returns {found, index} of the first valid requester strictly after last.
  function automatic logic [IdxW:0] pick(input logic [NumReq-1:0] v,
                                         input logic [IdxW-1:0]   last);
    logic [IdxW:0] r;
    int            idx;
    r = '0;
    for (int i = NumReq; i >= 1; i--) begin
      idx = (int'(last) + i) % NumReq;
      if (v[idx[IdxW-1:0]]) begin
        r = {1'b1, idx[IdxW-1:0]};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign out_free = ~valid_q | desc_addr_ready_i;
  assign id_space = (count_q < FullCnt) | desc_done_i;
  assign {found, winner} = pick(req_valid_i, last_q);
  assign grant = out_free & id_space & found;
  assign pop   = desc_done_i & (count_q != '0);

  always_comb begin
    req_ready_o = '0;
    if (grant) begin
      req_ready_o = NumReq'(1) << winner;
    end else begin
      req_ready_o = '0;
    end
  end

  // A simultaneous push and pop at full is legal: the write slot equals the
  // read slot, and the read below still sees the old entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      addr_q   <= '0;
      last_q   <= IdxW'(NumReq - 1);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (grant) begin
        valid_q          <= 1'b1;
        addr_q           <= req_addr_i[winner];
        last_q           <= winner;
        fifo_q[wr_ptr_q] <= winner;
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end else if (desc_addr_ready_i) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_q;
      end

      if (pop) begin
        done_q   <= NumReq'(1) << fifo_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end else begin
        done_q <= '0;
      end

      if (grant && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !grant) begin
        count_q <= count_q - CntW'(1);
      end else begin
        count_q <= count_q;
      end

      if (desc_done_i && (count_q == '0)) begin
        err_q <= 1'b1;
      end else begin
        err_q <= err_q;
      end
    end
  end

  assign desc_addr_valid_o = valid_q;
  assign desc_addr_o       = addr_q;
  assign req_done_o        = done_q;
  assign outstanding_o     = count_q;
  assign busy_o            = valid_q | (count_q != '0);
  assign err_o             = err_q;

endmodule

// File: tb/tb_idma_desc64_submit_arb.sv
// Self-checking bench for idma_desc64_submit_arb: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_idma_desc64_submit_arb;
  localparam int N  = 4;
  localparam int AW = 64;
  localparam int D  = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req_valid;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0]           req_ready;
  logic                   desc_addr_valid;
  logic [AW-1:0]          desc_addr;
  logic                   desc_addr_ready;
  logic                   desc_done;
  logic [N-1:0]           req_done;
  logic [$clog2(D+1)-1:0] outstanding;
  logic                   busy;
  logic                   err;

  idma_desc64_submit_arb #(.NumReq(N), .AddrWidth(AW), .IdDepth(D)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
    .desc_addr_valid_o(desc_addr_valid), .desc_addr_o(desc_addr),
    .desc_addr_ready_i(desc_addr_ready), .desc_done_i(desc_done),
    .req_done_o(req_done), .outstanding_o(outstanding), .busy_o(busy),
    .err_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: what the frontend should see and what is owed back.
  bit            m_valid;
  logic [AW-1:0] m_addr;
  int            m_last;
  int            m_ids[$];
  logic [N-1:0]  m_done;
  bit            m_err;
  int            last_grant;
  int            grant_log[$];

  bit            pend_valid[N];
  logic [AW-1:0] pend_addr[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_addr = '0; m_last = N - 1; m_ids.delete();
    m_done = '0; m_err = 1'b0;
  endtask

  // Called just after a negedge with inputs driven; returns at the next negedge.
  task automatic step();
    int           w;
    logic [N-1:0] exp_ready;
    #1;
    w = -1;
    exp_ready = '0;
    if ((!m_valid || desc_addr_ready) && (m_ids.size() < D || desc_done)) begin
      for (int k = 1; k <= N; k++) begin
        if (w < 0 && req_valid[(m_last + k) % N]) w = (m_last + k) % N;
      end
    end
    if (w >= 0) exp_ready[w] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    chk("addr_valid", desc_addr_valid, m_valid);
    chk("addr", desc_addr, m_addr);
    chk("outstanding", outstanding, m_ids.size());
    chk("busy", busy, m_valid || (m_ids.size() != 0));
    chk("err", err, m_err);
    chk("req_done", req_done, m_done);
    @(posedge clk);
    if (rst) begin
      model_reset();
      w = -1;
    end else begin
      m_done = '0;
      if (desc_done) begin
        if (m_ids.size() > 0) begin
          m_done[m_ids[0]] = 1'b1;
          void'(m_ids.pop_front());
        end else begin
          m_err = 1'b1;
        end
      end
      if (w >= 0) begin
        m_ids.push_back(w);
        m_addr = req_addr[w];
        m_valid = 1'b1;
        m_last = w;
        grant_log.push_back(w);
      end else if (desc_addr_ready) begin
        m_valid = 1'b0;
      end
    end
    last_grant = w;
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = '0; desc_done = 1'b0; rst = 1'b0; desc_addr_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; step(); rst = 1'b0;
  endtask

  int cnt[N];

  initial begin
    idle();
    req_addr = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Reset state
    #1;
    chk("reset_valid", desc_addr_valid, 1'b0);
    chk("reset_outstanding", outstanding, 0);
    chk("reset_err", err, 1'b0);
    step();

    // Single request from requester 2
    req_valid = 4'b0100; req_addr[2] = 64'h1000;
    #1 chk("single_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    chk("single_valid", desc_addr_valid, 1'b1);
    chk("single_addr", desc_addr, 64'h1000);
    chk("single_outstanding", outstanding, 1);
    repeat (4) step();
    desc_done = 1'b1; step(); desc_done = 1'b0;
    chk("single_done", req_done, 4'b0100);
    chk("single_drained", outstanding, 0);
    step();

    // Round robin, then fill the ID FIFO
    do_reset();
    grant_log.delete();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) req_addr[i] = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) begin
      step();
      if (last_grant >= 0) req_addr[last_grant] = {$urandom, $urandom};
    end
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int i = 0; i < grant_log.size(); i++) begin
      chk("rr_order", grant_log[i], i % N);
      cnt[grant_log[i]]++;
    end
    for (int i = 0; i < N; i++) chk("rr_share", cnt[i], 2);
    chk("full_outstanding", outstanding, D);
    #1 chk("full_ready", req_ready, 4'b0000);
    step();
    desc_done = 1'b1;
    #1 chk("full_done_grant", req_ready, 4'b0001);
    step();
    chk("full_stays", outstanding, D);
    chk("full_first_done", req_done, 4'b0001);
    req_valid = '0;
    repeat (D) step();
    desc_done = 1'b0;
    step();
    chk("full_drained", outstanding, 0);

    // Backpressure
    do_reset();
    req_valid = 4'b0010; req_addr[1] = 64'hA0;
    step();
    req_valid = 4'b1000; req_addr[3] = 64'hB0; desc_addr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_no_ready", req_ready, 4'b0000);
      chk("bp_addr_held", desc_addr, 64'hA0);
      step();
    end
    desc_addr_ready = 1'b1;
    #1 chk("bp_grant_on_accept", req_ready, 4'b1000);
    step();
    req_valid = '0;
    chk("bp_next_addr", desc_addr, 64'hB0);
    step();

    // Spurious done
    do_reset();
    desc_done = 1'b1; step(); desc_done = 1'b0;
    chk("spurious_err", err, 1'b1);
    chk("spurious_no_done", req_done, 4'b0000);
    repeat (3) step();
    chk("spurious_sticky", err, 1'b1);
    do_reset();
    chk("spurious_cleared", err, 1'b0);

    // Reset mid-flight
    req_valid = 4'b0110; req_addr[1] = 64'h11; req_addr[2] = 64'h22;
    repeat (3) step();
    desc_addr_ready = 1'b0;
    step();
    chk("mid_outstanding", outstanding, 3);
    do_reset();
    chk("mid_valid", desc_addr_valid, 1'b0);
    chk("mid_cleared", outstanding, 0);
    chk("mid_busy", busy, 1'b0);
    req_valid = 4'b1111;
    #1 chk("mid_first_grant", req_ready, 4'b0001);
    step();
    idle();
    desc_done = 1'b1; step(); desc_done = 1'b0;

    // Randomized traffic
    do_reset();
    for (int k = 0; k < N; k++) pend_valid[k] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend_valid[k] && ($urandom_range(0, 2) == 0)) begin
          pend_valid[k] = 1'b1;
          pend_addr[k] = {$urandom, $urandom};
        end
      end
      rst = ($urandom_range(0, 499) == 0);
      desc_addr_ready = ($urandom_range(0, 3) != 0);
      if (m_ids.size() > 0) desc_done = ($urandom_range(0, 2) == 0);
      else desc_done = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < N; k++) begin
        req_valid[k] = pend_valid[k] && !rst;
        req_addr[k] = pend_addr[k];
      end
      step();
      if (last_grant >= 0) pend_valid[last_grant] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
